// File: rtl/adder_pkg.sv
// Shared types and sizing helpers for the multi-cycle carry-lookahead adder.
package adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk_f(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Index width never drops below 1 so a single-chunk build still has a k register.
  function automatic int idx_w_f(input int nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Combinational CHUNK-bit carry-lookahead slice with fully flattened carry terms.
module cla_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             c_in,
  output logic [CHUNK-1:0] s,
  output logic             c_out
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  // Carry into bit i+1 is the OR of every generate (or c_in) propagated up to bit i.
  always_comb begin
    logic term;
    logic cy;
    c    = '0;
    term = 1'b0;
    cy   = 1'b0;
    c[0] = c_in;
    for (int i = 0; i < CHUNK; i++) begin
      term = c_in;
      for (int j = 0; j <= i; j++) term = term & p[j];
      cy = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        cy = cy | term;
      end
      c[i+1] = cy;
    end
  end

  assign s     = p ^ c[CHUNK-1:0];
  assign c_out = c[CHUNK];

endmodule

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder/subtractor: one shared CLA slice walks the operands CHUNK bits
// per cycle with the carry registered between slices; valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready high
//   RUN   | adding chunk k each cycle, carry held in carry_q
//   DONE  | result held, out_valid high until out_ready
module seq_cla_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCHUNK = nchunk_f(WIDTH, CHUNK);
  localparam int KW     = idx_w_f(NCHUNK);

  if (CHUNK < 1 || WIDTH < CHUNK || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("seq_cla_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  state_t            state, state_nxt;
  logic [KW-1:0]     k;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [CHUNK-1:0]  slice_s;
  logic              slice_c;
  logic              last;
  logic              accept;

  assign last   = (k == KW'(NCHUNK - 1));
  assign accept = (state == IDLE) && in_valid;

  cla_slice #(.CHUNK(CHUNK)) u_slice (
    .a     (a_q[k*CHUNK +: CHUNK]),
    .b     (b_q[k*CHUNK +: CHUNK]),
    .c_in  (carry_q),
    .s     (slice_s),
    .c_out (slice_c)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN:  if (last) state_nxt = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k       <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      k       <= '0;
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : cin;
    end else if (state == RUN) begin
      sum_q[k*CHUNK +: CHUNK] <= slice_s;
      carry_q                 <= slice_c;
      k                       <= k + KW'(1);
      if (last) begin
        cout_q <= slice_c;
        ovf_q  <= slice_s[CHUNK-1] ^ a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ slice_c;
      end
    end
  end

  assign sum      = sum_q;
  assign cout     = cout_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_seq_cla_adder.sv
// Directed self-checking bench for seq_cla_adder at WIDTH=16, CHUNK=4.
module tb_seq_cla_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        cin, sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout, overflow;

  int tests = 0;
  int fails = 0;

  seq_cla_adder #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accepts one operation, measures latency to out_valid, checks the result and
  // releases it; the wait is bounded so a stuck DUT still reaches the summary.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic ci, input logic sb,
                        input logic [15:0] es, input logic ec, input logic eo);
    int n;
    a = av; b = bv; cin = ci; sub = sb; in_valid = 1'b1;
    chk({tag, "_in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 4);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, overflow, eo);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_back_idle"}, in_ready, 1);
  endtask

  initial begin
    int seen;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", overflow, 0);

    run_op("add", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0000, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_neg", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);

    // Backpressure with input churn during RUN and DONE.
    a = 16'h1000; b = 16'h0234; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      chk("run_in_ready", in_ready, 0);
      chk("run_out_valid", out_valid, 0);
      a = 16'hA5A5 ^ 16'(i); b = 16'h5A5A; sub = i[0]; cin = ~i[0];
      in_valid = ~in_valid;
      step();
    end
    for (int i = 0; i < 3; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_sum", sum, 16'h1234);
      chk("bp_cout", cout, 0);
      chk("bp_ovf", overflow, 0);
      a = 16'hFFFF; b = 16'hFFFF; in_valid = ~in_valid;
      step();
    end
    in_valid = 1'b0;
    chk("bp_sum_final", sum, 16'h1234);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_release_out_valid", out_valid, 0);

    // Reset in the third RUN cycle aborts the operation.
    a = 16'h4444; b = 16'h4444; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_sum", sum, 16'h0000);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_valid) seen++;
      step();
    end
    chk("abort_no_result", seen, 0);
    run_op("post_abort", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_cla_adder.md
# seq_cla_adder

Parametrised multi-cycle carry-lookahead adder/subtractor. Operands of WIDTH bits are processed CHUNK bits per cycle through one shared CHUNK-bit lookahead slice, with the carry registered between slices. Valid/ready handshakes sit on both sides, so the block drops into the lab datapath wherever a wide add is needed without a wide combinational carry chain.

## Interface
- WIDTH, 32, operand and result width; must be a multiple of CHUNK.
- CHUNK, 4, bits added per cycle; width of the lookahead slice; CHUNK ≥ 1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operands valid.
- in_ready  output  1  block can accept operands; high exactly in IDLE.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a−b, computed as a+~b+1.
- out_valid  output  1  result valid; high exactly in DONE.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of the MSB; for sub, 1 means no borrow.
- overflow  output  1  two's-complement signed overflow.

## Operation
- NCHUNK = WIDTH/CHUNK. An illegal WIDTH/CHUNK pair is an elaboration error.
- FSM states are IDLE, RUN and DONE.
- IDLE:
  - On in_valid && in_ready, register a, the effective b (b, or ~b when sub=1) and the effective carry (cin, or 1 when sub=1).
  - Clear the chunk index k to 0 and go to RUN.
  - in_valid low: stay in IDLE.
- RUN, each cycle:
  - Slice k adds a[k·CHUNK +: CHUNK], b_eff[k·CHUNK +: CHUNK] and the carry register.
  - Write the slice sum into sum[k·CHUNK +: CHUNK], write the slice carry-out into the carry register, then k++.
  - After slice NCHUNK−1, go to DONE.
- Flag capture on the final slice:
  - cout = slice carry-out.
  - overflow = (carry into bit WIDTH−1) XOR cout.
  - Carry into bit WIDTH−1 = sum[WIDTH−1] ^ a[WIDTH−1] ^ b_eff[WIDTH−1].
- DONE:
  - Hold sum, cout and overflow stable.
  - On out_ready, go to IDLE.
- Inputs a, b, cin and sub are sampled only on the accept edge. Changes at any other time have no effect.
- in_valid while not in IDLE is ignored; no queueing.
- Reset values: state IDLE, in_ready=1, out_valid=0, sum=0, cout=0, overflow=0, k=0, carry register 0.
- rst has priority over everything. Reset during RUN or DONE aborts the operation; no result is ever presented for it.
- Wrap-around: results are modulo 2^WIDTH, and the carry out of the MSB appears only on cout.

## Timing
- Accept edge at the end of cycle T.
- RUN occupies cycles T+1 … T+NCHUNK.
- out_valid is first high in cycle T+NCHUNK+1.
- Result latency is NCHUNK+1 cycles from the accept edge.
- With out_ready high in cycle T+NCHUNK+1, in_ready is high in T+NCHUNK+2.
- Best-case throughput is one operation per NCHUNK+2 cycles.
- Outputs are registered. Only in_ready and out_valid are decoded from state, with no combinational path from inputs.
- Upper sum chunks not yet written during RUN hold stale values. Consumers sample sum only while out_valid is high.

## Structure
- Shared package adder_pkg holds:
  - the state typedef (IDLE, RUN, DONE), 2-bit encoding;
  - a function computing NCHUNK;
  - the index-width constant $clog2(NCHUNK), minimum 1.
- Sub-module cla_slice: purely combinational, parameter CHUNK.
  - Per-bit generate/propagate, flattened lookahead carries and sum.
  - Ports a, b, c_in, s, c_out.
  - Instantiated once.
- Top-level module holds the FSM, k counter, operand registers, carry register and result register.

## Test plan
All scenarios run with WIDTH=16, CHUNK=4 (NCHUNK=4) unless stated.
- Reset: rst high for 2 cycles, then low → in_ready=1, out_valid=0, sum=0x0000, cout=0, overflow=0.
- Add: a=0x00FF, b=0x0001, cin=0, sub=0, accepted at T → out_valid first high at T+5, sum=0x0100, cout=0, overflow=0.
- Add boundaries:
  - 0xFFFF+0x0001, cin=0 → sum=0x0000, cout=1, overflow=0.
  - 0x7FFF+0x0000, cin=1 → sum=0x8000, cout=0, overflow=1.
- Subtract:
  - a=0x8000, b=0x0001, sub=1, cin=1 (must be ignored) → sum=0x7FFF, cout=1, overflow=1.
  - a=0x0003, b=0x0005, sub=1 → sum=0xFFFE, cout=0, overflow=0.
- Backpressure and ignored inputs:
  - Hold out_ready low for 3 cycles in DONE → sum and flags stable, in_ready=0.
  - Toggle in_valid, a and b during RUN and DONE → no effect.
  - Raise out_ready → IDLE next cycle.
- Reset mid-operation: assert rst in the 3rd RUN cycle → IDLE next cycle, out_valid never rises. A fresh 0x1234+0x1111 then yields 0x2345.
